csa_ecm_fetch: RTL

- Sits directly downstream of the ECM scheduler.
- Queues each 36-bit ECM address request, fetches the addressed 188-byte ECM TS packet from packet memory over a byte-wide read interface, and patches the TS continuity counter from the request.
- Emits the packet as a framed byte stream towards the TS output mux.
- Guards against FIFO overflow, bad sync byte and stalled memory reads.

---
 rtl/csa_ecm_fetch.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/csa_ecm_fetch.sv
// ECM packet fetch: queues validated ECM address requests, reads each 188-byte
// ECM TS packet from packet memory, patches the continuity counter and emits
// the packet as a framed byte stream.
module csa_ecm_fetch #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned PKT_LEN    = 188,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] ecm_addr_din,
  input  logic        ecm_addr_din_en,
  output logic        mem_rd_req,
  output logic [26:0] mem_rd_addr,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rd_data,
  input  logic        mem_rd_data_en,
  output logic [7:0]  ts_dout,
  output logic        ts_dout_en,
  output logic        ts_dout_sop,
  output logic        ts_dout_eop,
  output logic        ts_dout_err,
  output logic        fifo_ovf,
  output logic        sync_err,
  output logic        req_drop
);

  localparam int unsigned CW = FIFO_AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StRecv, StDrain} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [22:0]        fifo_mem [FIFO_DEPTH];
  logic [22:0]        head;
  logic               req_ok, full, push, pop;
  logic [3:0]         cc_q, cc_d;
  logic [18:0]        base_q, base_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [7:0]         dout_q, dout_d;
  logic               en_q, en_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic               ovf_q, ovf_d, sync_q, sync_d, drop_q, drop_d;
  logic               unused_offset;

  // Byte offset field is always zero and carries no information.
  assign unused_offset = ^ecm_addr_din[7:0];

  assign req_ok = ecm_addr_din[31] && (ecm_addr_din[30:27] == 4'b0010);
  assign full   = (count_q == CW'(FIFO_DEPTH));
  // Holding off one cycle after an eop keeps two cycles between eop and the next read request.
  assign pop    = (state_q == StIdle) && (count_q != '0) && !eop_q;
  // A full FIFO still takes the write when the head is popped in the same cycle.
  assign push   = ecm_addr_din_en && req_ok && (!full || pop);
  assign ovf_d  = ecm_addr_din_en && req_ok && full && !pop;
  assign drop_d = ecm_addr_din_en && !req_ok;
  assign head   = fifo_mem[rptr_q];

  // Request FIFO storage; no reset needed, validity tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= {ecm_addr_din[35:32], ecm_addr_din[26:8]};
  end

  // Request FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Fetch FSM next state and registered output beat.
  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    dout_d  = 8'h00;
    en_d    = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    sync_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          cc_d    = head[22:19];
          base_d  = head[18:0];
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_rd_ack) begin
          cnt_d   = '0;
          timer_d = '0;
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (mem_rd_data_en) begin
          cnt_d   = cnt_q + 1'b1;
          timer_d = '0;
          if (cnt_q == 8'd0) begin
            if (mem_rd_data == 8'h47) begin
              en_d   = 1'b1;
              sop_d  = 1'b1;
              dout_d = mem_rd_data;
            end else begin
              sync_d  = 1'b1;
              state_d = StDrain;
            end
          end else begin
            en_d   = 1'b1;
            dout_d = (cnt_q == 8'd3) ? {mem_rd_data[7:4], cc_q} : mem_rd_data;
            if (cnt_q == 8'(PKT_LEN - 1)) begin
              eop_d   = 1'b1;
              state_d = StIdle;
            end
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // A nonzero byte count means sop already left, so close the frame with an error beat.
          if (cnt_q != 8'd0) begin
            en_d  = 1'b1;
            eop_d = 1'b1;
            err_d = 1'b1;
          end
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDrain: begin
        if (mem_rd_data_en) begin
          cnt_d   = cnt_q + 1'b1;
          timer_d = '0;
          if (cnt_q == 8'(PKT_LEN - 1)) state_d = StIdle;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, packet context and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cc_q    <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      dout_q  <= '0;
      en_q    <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      sync_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      sync_q  <= sync_d;
      drop_q  <= drop_d;
    end
  end

  assign mem_rd_req  = (state_q == StReq);
  assign mem_rd_addr = {base_q, 8'h00};
  assign ts_dout     = dout_q;
  assign ts_dout_en  = en_q;
  assign ts_dout_sop = sop_q;
  assign ts_dout_eop = eop_q;
  assign ts_dout_err = err_q;
  assign fifo_ovf    = ovf_q;
  assign sync_err    = sync_q;
  assign req_drop    = drop_q;

endmodule
